// File: rtl/addr_pkg.sv
// rtl/addr_pkg.sv - shared types and constants for the address generator
package addr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic MODE_DIRECT  = 1'b0;
    localparam logic MODE_INDEXED = 1'b1;

    // Field width for a count of n items, never narrower than one bit
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addr_gen_if.sv
// rtl/addr_gen_if.sv - request and memory-beat bundle for addr_gen
interface addr_gen_if #(
    parameter int AW   = 8,
    parameter int NSRC = 4,
    parameter int MAXB = 4
) ();
    import addr_pkg::*;

    localparam int SW = width_of(NSRC);
    localparam int BW = width_of(MAXB);

    // request side
    logic [NSRC*AW-1:0] src_addr;
    logic [SW-1:0]      sel;
    logic               mode;
    logic [AW-1:0]      offset;
    logic [BW-1:0]      burst_len;
    logic               req_valid;
    logic               req_ready;

    // memory side and status
    logic [AW-1:0]      mem_addr;
    logic               mem_valid;
    logic               mem_ready;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
        output src_addr, sel, mode, offset, burst_len, req_valid, mem_ready,
        input  req_ready, mem_addr, mem_valid, busy, done, wrap
    );

    modport slave (
        input  src_addr, sel, mode, offset, burst_len, req_valid, mem_ready,
        output req_ready, mem_addr, mem_valid, busy, done, wrap
    );

endinterface

// File: rtl/addr_src_mux.sv
// rtl/addr_src_mux.sv - picks one packed source address, out-of-range select falls back to source 0
module addr_src_mux
    import addr_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int AW   = 8
) (
    input  logic [NSRC*AW-1:0]           src_addr_i,
    input  logic [width_of(NSRC)-1:0]    sel_i,
    output logic [AW-1:0]                addr_o
);

    localparam int SW = width_of(NSRC);

    // Default to source 0 so any select beyond NSRC-1 lands there
    always_comb begin
        addr_o = src_addr_i[0 +: AW];
        for (int i = 1; i < NSRC; i++) begin
            if (sel_i == SW'(i)) begin
                addr_o = src_addr_i[i*AW +: AW];
            end
        end
    end

endmodule

// File: rtl/addr_gen.sv
// rtl/addr_gen.sv - burst address generator: base select/index, beat counter, wrap and done pulses
module addr_gen
    import addr_pkg::*;
#(
    parameter int AW   = 8,
    parameter int NSRC = 4,
    parameter int MAXB = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    addr_gen_if.slave  bus
);

    localparam int BW = width_of(MAXB);
    // burst_len can only exceed MAXB-1 when MAXB is not a power of two
    localparam bit NEED_CLAMP = (MAXB < (1 << BW));

    state_t         state_q;
    logic [AW-1:0]  mem_addr_q;
    logic [BW-1:0]  beat_q;
    logic [BW-1:0]  len_q;
    logic           done_q;
    logic           wrap_q;

    logic [AW-1:0]  src_sel;
    logic [AW-1:0]  base_d;
    logic [BW-1:0]  len_d;

    addr_src_mux #(
        .NSRC (NSRC),
        .AW   (AW)
    ) u_src_mux (
        .src_addr_i (bus.src_addr),
        .sel_i      (bus.sel),
        .addr_o     (src_sel)
    );

    // Base address: selected source, plus offset in indexed mode (carry dropped)
    always_comb begin
        base_d = src_sel;
        case (bus.mode)
            MODE_DIRECT:  base_d = src_sel;
            MODE_INDEXED: base_d = src_sel + bus.offset;
            default:      base_d = src_sel;
        endcase
    end

    generate
        if (NEED_CLAMP) begin : g_clamp
            // Over-long bursts are cut to the longest legal burst
            always_comb begin
                len_d = bus.burst_len;
                if (bus.burst_len > BW'(MAXB - 1)) begin
                    len_d = BW'(MAXB - 1);
                end
            end
        end else begin : g_noclamp
            assign len_d = bus.burst_len;
        end
    endgenerate

    // Burst FSM: captures the request, steps the address per accepted beat, pulses done/wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            beat_q     <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            if (state_q == IDLE) begin
                if (bus.req_valid) begin
                    state_q    <= BURST;
                    mem_addr_q <= base_d;
                    beat_q     <= '0;
                    len_q      <= len_d;
                end
            end else if (bus.mem_ready) begin
                if (beat_q == len_q) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end else begin
                    mem_addr_q <= mem_addr_q + AW'(1);
                    beat_q     <= beat_q + BW'(1);
                    wrap_q     <= &mem_addr_q;
                end
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.mem_valid = (state_q == BURST);
    assign bus.busy      = (state_q == BURST);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.done      = done_q;
    assign bus.wrap      = wrap_q;

endmodule
